// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        CHECK,
        DATA,
        RUN,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_START,
        PH_DATA,
        PH_STOP
    } uart_phase_t;

    localparam int LEN_W  = 16;
    localparam int BYTE_W = 8;

endpackage

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver; expects an already-synchronised serial input.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_sync,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] byte_data,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    uart_phase_t       phase;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        bit_idx;
    logic [BYTE_W-1:0] shreg;
    logic              rx_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= PH_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            rx_prev    <= 1'b1;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (phase)
                PH_IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_sync) phase <= PH_START;
                end
                // Mid-start re-check rejects short glitches on the line
                PH_START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        phase   <= rx_sync ? PH_IDLE : PH_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PH_DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[BYTE_W-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) phase <= PH_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PH_STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        phase <= PH_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/imem_uart_loader.sv
// Boot loader: receives a length-prefixed program over UART, writes it to
// instruction memory and holds the core in reset until the load completes.
module imem_uart_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 8,
    parameter int IMEM_DEPTH   = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  words_loaded
);

    localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(IMEM_DEPTH);

    logic              rx_sync_p0, rx_sync_p1;
    logic              byte_valid, frame_err;
    logic [BYTE_W-1:0] byte_data;
    state_t            state;
    logic [LEN_W-1:0]  len;
    logic [1:0]        byte_idx;
    logic [23:0]       word_buf;
    logic              bad_len, to_err;

    // Stage p0/p1: two-flop synchroniser for the asynchronous serial line
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= rx;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx_sync    (rx_sync_p1),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign bad_len = (len == '0) || ({1'b0, len} > DEPTH_L);
    assign to_err  = (busy && frame_err) || (state == CHECK && bad_len);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LEN_LO;
            len          <= '0;
            byte_idx     <= '0;
            cpu_reset    <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            imem_we      <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            if (to_err) begin
                state     <= ERR;
                cpu_reset <= 1'b1;
                busy      <= 1'b0;
                error     <= 1'b1;
            end else begin
                case (state)
                    LEN_LO: if (byte_valid) begin
                        len[7:0] <= byte_data;
                        state    <= LEN_HI;
                    end
                    LEN_HI: if (byte_valid) begin
                        len[15:8] <= byte_data;
                        state     <= CHECK;
                    end
                    CHECK: state <= DATA;
                    DATA: begin
                        if (byte_valid) begin
                            byte_idx <= byte_idx + 2'd1;
                            case (byte_idx)
                                2'd0: word_buf[7:0]   <= byte_data;
                                2'd1: word_buf[15:8]  <= byte_data;
                                2'd2: word_buf[23:16] <= byte_data;
                                default: begin
                                    imem_we      <= 1'b1;
                                    imem_waddr   <= words_loaded[ADDR_W-1:0];
                                    imem_wdata   <= {byte_data, word_buf};
                                    words_loaded <= words_loaded + 16'd1;
                                end
                            endcase
                        end
                        // words_loaded already counts the write now on the bus
                        if (imem_we && words_loaded == len) begin
                            state     <= RUN;
                            cpu_reset <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                    RUN, ERR: if (load_req) begin
                        state        <= LEN_LO;
                        len          <= '0;
                        byte_idx     <= '0;
                        words_loaded <= '0;
                        cpu_reset    <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                    end
                    default: state <= ERR;
                endcase
            end
        end
    end

endmodule
